// File: rtl/mul_seq.sv
// Sequential 32x32 multiplier, low 32 bits of the product, with optional accumulate (MUL/MLA).
// Uses one shift-and-add step per cycle through an external shared ALU that
// is fixed to the ADD command. The optional ACC cycle adds rn to the product.
// With EARLY_TERM set, iteration stops once no set multiplier bits remain.
module mul_seq #(
  parameter int unsigned EARLY_TERM  = 1,
  // Value of ADD_ALU_CMD in the shared constants file (the ADD data-processing opcode).
  parameter logic [3:0]  ADD_ALU_CMD = 4'b0100
) (
  input  logic        clk,
  input  logic        rst,          // asynchronous, active-low
  input  logic        start,
  input  logic        accumulate,
  input  logic [31:0] rm,
  input  logic [31:0] rs,
  input  logic [31:0] rn,
  input  logic [3:0]  sr_in,        // {z,c,n,v}
  input  logic [31:0] alu_res,
  output logic [31:0] alu_val_1,
  output logic [31:0] alu_val_2,
  output logic [3:0]  alu_exec_cmd,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] result,
  output logic [3:0]  status_out    // {z,c,n,v}
);

  typedef enum logic [1:0] {IDLE, ITER, ACC, DONE} state_e;

  state_e      state_q;
  logic [31:0] product_q;
  logic [31:0] mcand_q;
  logic [31:0] mplier_q;
  logic [31:0] rn_q;
  logic [5:0]  count_q;
  logic        acc_q;
  logic        sr_c_q;
  logic        sr_v_q;
  // Set once an operation has been started; keeps z at 0 straight out of reset.
  logic        valid_q;

  logic [31:0] mplier_d;
  logic        last_iter;

  // Shifted multiplier and the loop-exit decision for the current ITER cycle.
  always_comb begin
    mplier_d  = mplier_q >> 1;
    last_iter = (count_q == 6'd31) || ((EARLY_TERM != 0) && (mplier_d == '0));
  end

  // Control FSM and datapath registers.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      product_q <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      rn_q      <= '0;
      count_q   <= '0;
      acc_q     <= 1'b0;
      sr_c_q    <= 1'b0;
      sr_v_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q   <= rm;
            mplier_q  <= rs;
            rn_q      <= rn;
            acc_q     <= accumulate;
            sr_c_q    <= sr_in[2];
            sr_v_q    <= sr_in[0];
            product_q <= '0;
            count_q   <= '0;
            valid_q   <= 1'b1;
            state_q   <= ITER;
          end
        end
        ITER: begin
          if (mplier_q[0]) begin
            product_q <= alu_res;
          end
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_d;
          count_q  <= count_q + 6'd1;
          if (last_iter) begin
            state_q <= acc_q ? ACC : DONE;
          end
        end
        ACC: begin
          product_q <= alu_res;
          state_q   <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // ALU operand steering; both operands are zero outside ITER and ACC.
  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    alu_val_1 = '0;
    alu_val_2 = '0;
    case (state_q)
      ITER: begin
        alu_val_1 = product_q;
        alu_val_2 = mcand_q;
      end
      ACC: begin
        alu_val_1 = product_q;
        alu_val_2 = rn_q;
      end
      default: begin
      end
    endcase
  end

  assign alu_exec_cmd = ADD_ALU_CMD;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  // rst gates the start term so that stall stays low while reset is held.
  assign stall        = rst & ((start & (state_q == IDLE)) | (busy & (state_q != DONE)));
  assign result       = product_q;
  assign status_out   = {valid_q & (product_q == '0), sr_c_q, product_q[31], sr_v_q};

endmodule

// File: tb/tb_mul_seq.sv
// Directed testbench for mul_seq: one instance with EARLY_TERM=1, one with EARLY_TERM=0.
// Each instance has a behavioural adder standing in for the shared ALU.
module tb_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start0;
  logic        acc;
  logic [31:0] rm, rs, rn;
  logic [3:0]  sr;

  logic [31:0] alu_res1, alu_v1_1, alu_v2_1, result1;
  logic [3:0]  cmd1, status1;
  logic        busy1, stall1, done1;

  logic [31:0] alu_res0, alu_v1_0, alu_v2_0, result0;
  logic [3:0]  cmd0, status0;
  logic        busy0, stall0, done0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign alu_res1 = alu_v1_1 + alu_v2_1;
  assign alu_res0 = alu_v1_0 + alu_v2_0;

  mul_seq #(.EARLY_TERM(1)) dut_fast (
    .clk(clk), .rst(rst), .start(start1), .accumulate(acc),
    .rm(rm), .rs(rs), .rn(rn), .sr_in(sr), .alu_res(alu_res1),
    .alu_val_1(alu_v1_1), .alu_val_2(alu_v2_1), .alu_exec_cmd(cmd1),
    .busy(busy1), .stall(stall1), .done(done1),
    .result(result1), .status_out(status1)
  );

  mul_seq #(.EARLY_TERM(0)) dut_full (
    .clk(clk), .rst(rst), .start(start0), .accumulate(acc),
    .rm(rm), .rs(rs), .rn(rn), .sr_in(sr), .alu_res(alu_res0),
    .alu_val_1(alu_v1_0), .alu_val_2(alu_v2_0), .alu_exec_cmd(cmd0),
    .busy(busy0), .stall(stall0), .done(done0),
    .result(result0), .status_out(status0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Runs one operation on the selected instance. Returns the latency counted in
  // clock edges from the start edge up to the one that raises done, and the
  // number of busy cycles with stall high. Returns at the negedge where done is high.
  task automatic run_op(input bit slow, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic mla,
                        output int lat, output int stl);
    @(negedge clk);
    rm = a; rs = b; rn = c; acc = mla; sr = 4'b0101;
    if (slow) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    lat = 1;
    stl = 0;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    sr = 4'b1010;  // flags change after the start edge; the DUT must keep the latched ones
    while (!(slow ? done0 : done1) && lat < 100) begin
      if (slow ? (busy0 && stall0) : (busy1 && stall1)) stl++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat, stl, done_cnt;
    rst = 1'b0; start1 = 1'b0; start0 = 1'b0; acc = 1'b0;
    rm = '0; rs = '0; rn = '0; sr = 4'b0101;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy",   busy1,      0);
    check("rst_stall",  stall1,     0);
    check("rst_done",   done1,      0);
    check("rst_result", result1,    0);
    check("rst_status", status1,    0);
    check("rst_alu1",   alu_v1_1,   0);
    check("alu_cmd",    cmd1,       32'h4);
    rst = 1'b1;
    @(negedge clk);

    // 3*5, MUL, early termination: 3 iterations
    run_op(0, 32'd3, 32'd5, 32'd0, 1'b0, lat, stl);
    check("mul15_lat",    lat,     4);
    check("mul15_stall",  stl,     3);
    check("mul15_result", result1, 32'd15);
    check("mul15_status", status1, 32'h5);
    check("mul15_done_stall", stall1, 0);
    @(negedge clk);
    check("mul15_done_pulse", done1,   0);
    check("mul15_idle",       busy1,   0);
    check("mul15_hold",       result1, 32'd15);
    check("idle_alu2",        alu_v2_1, 0);

    // MLA 0xFFFFFFFF*2 + 3 wraps to 1
    run_op(0, 32'hFFFF_FFFF, 32'd2, 32'd3, 1'b1, lat, stl);
    check("mla_lat",    lat,     4);
    check("mla_stall",  stl,     3);
    check("mla_result", result1, 32'h1);
    check("mla_status", status1, 32'h5);

    // rs = 0: single iteration, zero result
    run_op(0, 32'h1234_5678, 32'd0, 32'd0, 1'b0, lat, stl);
    check("zero_lat",    lat,     2);
    check("zero_result", result1, 0);
    check("zero_status", status1, 32'hD);

    // Negative times positive: -3*5 = -15, n flag set
    run_op(0, 32'hFFFF_FFFD, 32'd5, 32'd0, 1'b0, lat, stl);
    check("neg_lat",    lat,     4);
    check("neg_result", result1, 32'hFFFF_FFF1);
    check("neg_status", status1, 32'h7);

    // EARLY_TERM=0: always 32 iterations; 2^16*2^16 wraps to 0
    run_op(1, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, lat, stl);
    check("full_lat",    lat,     33);
    check("full_stall",  stl,     32);
    check("full_result", result0, 0);
    check("full_status", status0, 32'hD);
    check("full_done_stall", stall0, 0);

    // Start pulsed while busy must be ignored: 7*128 = 896, one done
    @(negedge clk);
    rm = 32'd7; rs = 32'd128; acc = 1'b0; sr = 4'b0101; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    rm = 32'd1; rs = 32'd1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    done_cnt = 0;
    repeat (20) begin
      if (done1) done_cnt++;
      @(negedge clk);
    end
    check("busy_start_dones",  done_cnt, 1);
    check("busy_start_result", result1,  32'd896);

    // Asynchronous reset in the middle of ITER
    @(negedge clk);
    rm = 32'd9; rs = 32'd255; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_busy", busy1, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_busy",   busy1,    0);
    check("arst_stall",  stall1,   0);
    check("arst_done",   done1,    0);
    check("arst_result", result1,  0);
    check("arst_status", status1,  0);
    check("arst_alu1",   alu_v1_1, 0);
    @(negedge clk);
    rst = 1'b1;

    // Clean restart after reset: 7*6 = 42
    run_op(0, 32'd7, 32'd6, 32'd0, 1'b0, lat, stl);
    check("post_rst_lat",    lat,     4);
    check("post_rst_result", result1, 32'd42);
    check("post_rst_status", status1, 32'h5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
